// File: rtl/four_bit_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_div_seq
// Purpose  : Sequential restoring divider (one quotient bit per clock) with a
//            start/busy/done handshake for the ALU division op.
// Revision : 1.0  initial release
// ============================================================================
module four_bit_div_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH:0]     r_p;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_div0;

    logic [WIDTH:0]     w_p_shift;
    logic [WIDTH+1:0]   w_trial;
    logic               w_qbit;
    logic [WIDTH:0]     w_p_nxt;
    logic [WIDTH-1:0]   w_dvd_nxt;
    logic               w_unused_p_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (b == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Trial subtract as p' + ~{0,divisor} + 1; the carry-out means p' >= divisor.
    always_comb begin
        w_p_shift = {r_p[WIDTH-1:0], r_dvd[WIDTH-1]};
        w_trial   = {1'b0, w_p_shift} + {1'b0, ~{1'b0, r_dvs}} + (WIDTH+2)'(1);
        w_qbit    = w_trial[WIDTH+1];
        w_p_nxt   = w_qbit ? w_trial[WIDTH:0] : w_p_shift;
        w_dvd_nxt = {r_dvd[WIDTH-2:0], w_qbit};
    end

    // A restored remainder is always below the divisor, so p's top bit never feeds the next shift.
    assign w_unused_p_msb = r_p[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_div0 <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            r_dvd  <= a;
                            r_dvs  <= b;
                            r_p    <= '0;
                            r_cnt  <= '0;
                            r_div0 <= 1'b0;
                        end else begin
                            r_q    <= '1;
                            r_r    <= a;
                            r_div0 <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_dvd <= w_dvd_nxt;
                    r_p   <= w_p_nxt;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_q <= w_dvd_nxt;
                        r_r <= w_p_nxt[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign q    = r_q;
    assign r    = r_r;
    assign div0 = r_div0;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_four_bit_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_four_bit_div_seq
// Purpose  : Self-checking bench for four_bit_div_seq (WIDTH=4 and WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_four_bit_div_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4;
    logic [3:0] a4, b4, q4, r4;
    logic       busy4, done4, div04;
    logic       start8;
    logic [7:0] a8, b8, q8, r8;
    logic       busy8, done8, div08;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    four_bit_div_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .q(q4), .r(r4), .busy(busy4), .done(done4), .div0(div04)
    );

    four_bit_div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .q(q8), .r(r8), .busy(busy8), .done(done8), .div0(div08)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Single WIDTH=4 operation: latency, busy length, results, one-cycle done.
    task automatic run_op4(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] eq,
                           input logic [3:0] er, input logic edz, input string tag);
        int n;
        int nb;
        @(negedge clk);
        a4 = ia; b4 = ib; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0; nb = 0;
        while (!done4 && n < 20) begin
            if (busy4) nb++;
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, 32'(done4), 32'd1);
        check({tag, " latency"}, n, (ib == 4'd0) ? 0 : 4);
        check({tag, " busy cycles"}, nb, (ib == 4'd0) ? 0 : 4);
        check({tag, " busy in done"}, 32'(busy4), 32'd0);
        check({tag, " q"}, 32'(q4), 32'(eq));
        check({tag, " r"}, 32'(r4), 32'(er));
        check({tag, " div0"}, 32'(div04), 32'(edz));
        @(negedge clk);
        check({tag, " done width"}, 32'(done4), 32'd0);
    endtask

    // start held high: count done pulses and their spacing.
    task automatic held_test(input logic [3:0] ia, input logic [3:0] ib, input int nneg,
                             input int exp_first, input int exp_gap, input string tag);
        int first;
        int last;
        int cnt;
        first = -1; last = -1; cnt = 0;
        @(negedge clk);
        a4 = ia; b4 = ib; start4 = 1'b1;
        for (int i = 1; i <= nneg; i++) begin
            @(negedge clk);
            if (done4) begin
                if (last >= 0) check({tag, " gap"}, i - last, exp_gap);
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        start4 = 1'b0;
        check({tag, " count"}, cnt, 3);
        check({tag, " first"}, first, exp_first);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        int ndone;
        logic [3:0] eq, er;
        logic [7:0] ra, rb;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
        vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[2] = '{4'd7,  4'd9,  4'd0,  4'd7, 1'b0};
        vecs[3] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[5] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1};
        vecs[6] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0};
        vecs[7] = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0};

        rst = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("reset q", 32'(q4), 32'd0);
        check("reset r", 32'(r4), 32'd0);
        check("reset busy", 32'(busy4), 32'd0);
        check("reset done", 32'(done4), 32'd0);
        check("reset div0", 32'(div04), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op4(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, $sformatf("vec%0d", i));
        end

        // Result hold after 13/3
        run_op4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, "basic");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold q", 32'(q4), 32'd4);
            check("hold r", 32'(r4), 32'd1);
        end

        // start and operand changes during RUN and DONE are ignored
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd2; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hs done", 32'(done4), 32'd1);
        check("hs q", 32'(q4), 32'd4);
        check("hs r", 32'(r4), 32'd1);
        a4 = 4'd6; b4 = 4'd2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("hs idle done", 32'(done4), 32'd0);
        @(negedge clk);
        check("hs idle busy", 32'(busy4), 32'd0);
        check("hs q kept", 32'(q4), 32'd4);

        held_test(4'd8, 4'd2, 20, 5, 6, "held");
        check("held q", 32'(q4), 32'd4);
        held_test(4'd9, 4'd0, 6, 1, 2, "held dz");
        held_test(4'd14, 4'd4, 20, 5, 6, "held2");

        // Reset in the second RUN cycle of 14/4
        @(negedge clk);
        a4 = 4'd14; b4 = 4'd4; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst q", 32'(q4), 32'd0);
        check("rst r", 32'(r4), 32'd0);
        check("rst busy", 32'(busy4), 32'd0);
        check("rst done", 32'(done4), 32'd0);
        check("rst div0", 32'(div04), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4 || busy4) ndone++;
        end
        check("rst no done", ndone, 0);
        run_op4(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, "after rst");

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                eq = (ib == 0) ? 4'd15 : 4'(ia / ib);
                er = (ib == 0) ? 4'(ia) : 4'(ia % ib);
                run_op4(4'(ia), 4'(ib), eq, er, (ib == 0), $sformatf("ex %0d/%0d", ia, ib));
            end
        end

        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (k % 10 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            @(negedge clk);
            a8 = ra; b8 = rb; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            n = 0;
            while (!done8 && n < 30) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("w8 %0d/%0d latency", ra, rb), n, (rb == 8'd0) ? 0 : 8);
            check($sformatf("w8 %0d/%0d q", ra, rb), 32'(q8), (rb == 8'd0) ? 32'd255 : 32'(ra / rb));
            check($sformatf("w8 %0d/%0d r", ra, rb), 32'(r8), (rb == 8'd0) ? 32'(ra) : 32'(ra % rb));
            check($sformatf("w8 %0d/%0d div0", ra, rb), 32'(div08), 32'(rb == 8'd0));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
